// File: rtl/picorv32_mem_arbiter_pkg.sv
// Shared types and helpers for the picorv32 instruction/data SRAM arbiter.
// Holds the bus word types, the response-owner encoding and the byte-strobe expansion.
package picorv32_mem_arbiter_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    function automatic logic [31:0] strb_to_wmask(strb_t strb);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/picorv32_mem_arb_prio.sv
// Grant decision between the instruction and data ports.
// Data wins by default; a waiting instruction fetch is forced through after MaxDataBurst data grants.
module picorv32_mem_arb_prio
    import picorv32_mem_arbiter_pkg::*;
#(
    parameter int unsigned MaxDataBurst = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic instr_req_i,
    input  logic data_req_i,
    output logic gnt_instr,
    output logic gnt_data
);

    localparam logic [3:0] BurstMax = 4'(MaxDataBurst);

    logic [3:0] burst_cnt;
    logic       instr_wins;

    always_comb begin
        instr_wins = instr_req_i && ((burst_cnt == BurstMax) || !data_req_i);
        gnt_instr  = !rst_i && instr_wins;
        gnt_data   = !rst_i && data_req_i && !instr_wins;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            burst_cnt <= '0;
        end else if (!instr_req_i || gnt_instr) begin
            burst_cnt <= '0;
        end else if (gnt_data && (burst_cnt != BurstMax)) begin
            burst_cnt <= burst_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Shares one single-port word SRAM between the picorv32 instruction and data ports.
// Translates byte addresses to word indices, rejects out-of-range accesses and routes responses back.
module picorv32_mem_arbiter
    import picorv32_mem_arbiter_pkg::*;
#(
    parameter int unsigned MemDepth     = 1 << 20,
    parameter addr_t       BaseAddr     = 32'h8000_0000,
    parameter int unsigned MaxDataBurst = 4,
    localparam int unsigned AddrW       = $clog2(MemDepth)
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             instr_req_i,
    output logic             instr_gnt_o,
    input  logic [31:0]      instr_addr_i,
    input  logic             instr_we_i,
    input  logic [31:0]      instr_wdata_i,
    input  logic [3:0]       instr_strb_i,
    output logic             instr_rvalid_o,
    output logic [31:0]      instr_rdata_o,
    output logic             instr_err_o,

    input  logic             data_req_i,
    output logic             data_gnt_o,
    input  logic [31:0]      data_addr_i,
    input  logic             data_we_i,
    input  logic [31:0]      data_wdata_i,
    input  logic [3:0]       data_strb_i,
    output logic             data_rvalid_o,
    output logic [31:0]      data_rdata_o,
    output logic             data_err_o,

    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic [31:0]      mem_wmask_o,
    input  logic [31:0]      mem_rdata_i
);

    // 33-bit span so a window covering the whole 4 GiB space still compares correctly.
    localparam logic [32:0] SpanBytes = 33'(MemDepth) * 33'd4;

    logic       gnt_instr;
    logic       gnt_data;
    logic       instr_in_range;
    logic       data_in_range;
    owner_e     rsp_owner;
    logic       rsp_err;

    picorv32_mem_arb_prio #(
        .MaxDataBurst(MaxDataBurst)
    ) u_prio (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .instr_req_i(instr_req_i),
        .data_req_i (data_req_i),
        .gnt_instr  (gnt_instr),
        .gnt_data   (gnt_data)
    );

    assign instr_gnt_o = gnt_instr;
    assign data_gnt_o  = gnt_data;

    // Addresses below BaseAddr wrap to huge offsets and fall outside the window.
    assign instr_in_range = {1'b0, instr_addr_i - BaseAddr} < SpanBytes;
    assign data_in_range  = {1'b0, data_addr_i - BaseAddr} < SpanBytes;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        if (gnt_instr && instr_in_range) begin
            mem_req_o   = 1'b1;
            mem_we_o    = instr_we_i;
            mem_addr_o  = AddrW'((instr_addr_i - BaseAddr) >> 2);
            mem_wdata_o = instr_wdata_i;
            mem_wmask_o = strb_to_wmask(instr_strb_i);
        end else if (gnt_data && data_in_range) begin
            mem_req_o   = 1'b1;
            mem_we_o    = data_we_i;
            mem_addr_o  = AddrW'((data_addr_i - BaseAddr) >> 2);
            mem_wdata_o = data_wdata_i;
            mem_wmask_o = strb_to_wmask(data_strb_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_owner <= OWN_NONE;
            rsp_err   <= 1'b0;
        end else if (gnt_instr) begin
            rsp_owner <= OWN_INSTR;
            rsp_err   <= !instr_in_range;
        end else if (gnt_data) begin
            rsp_owner <= OWN_DATA;
            rsp_err   <= !data_in_range;
        end else begin
            rsp_owner <= OWN_NONE;
            rsp_err   <= 1'b0;
        end
    end

    // Reset gates the response combinationally so a grant just before reset never acks.
    always_comb begin
        instr_rvalid_o = !rst_i && (rsp_owner == OWN_INSTR);
        data_rvalid_o  = !rst_i && (rsp_owner == OWN_DATA);
        instr_err_o    = instr_rvalid_o && rsp_err;
        data_err_o     = data_rvalid_o && rsp_err;
        instr_rdata_o  = (instr_rvalid_o && !rsp_err) ? mem_rdata_i : '0;
        data_rdata_o   = (data_rvalid_o && !rsp_err) ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Self-checking bench for picorv32_mem_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all cross-checked every cycle against a behavioural model.
module tb_picorv32_mem_arbiter;

    localparam int unsigned MEM_DEPTH = 1 << 20;
    localparam logic [31:0] BASE      = 32'h8000_0000;
    localparam int          MAX_BURST = 4;
    localparam logic [31:0] SPAN      = MEM_DEPTH * 4;

    logic        clk;
    logic        rst_i;
    logic        instr_req_i, instr_gnt_o, instr_we_i, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_addr_i, instr_wdata_i, instr_rdata_o;
    logic [3:0]  instr_strb_i;
    logic        data_req_i, data_gnt_o, data_we_i, data_rvalid_o, data_err_o;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic [3:0]  data_strb_i;
    logic        mem_req_o, mem_we_o;
    logic [19:0] mem_addr_o;
    logic [31:0] mem_wdata_o, mem_wmask_o, mem_rdata_i;

    int tests = 0;
    int fails = 0;

    picorv32_mem_arbiter #(
        .MemDepth    (MEM_DEPTH),
        .BaseAddr    (BASE),
        .MaxDataBurst(MAX_BURST)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .instr_req_i   (instr_req_i),
        .instr_gnt_o   (instr_gnt_o),
        .instr_addr_i  (instr_addr_i),
        .instr_we_i    (instr_we_i),
        .instr_wdata_i (instr_wdata_i),
        .instr_strb_i  (instr_strb_i),
        .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o (instr_rdata_o),
        .instr_err_o   (instr_err_o),
        .data_req_i    (data_req_i),
        .data_gnt_o    (data_gnt_o),
        .data_addr_i   (data_addr_i),
        .data_we_i     (data_we_i),
        .data_wdata_i  (data_wdata_i),
        .data_strb_i   (data_strb_i),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_wmask_o   (mem_wmask_o),
        .mem_rdata_i   (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model, checked on every falling edge ----------------
    // Tracks how many data accesses have overtaken a waiting fetch and the pending response.
    int          overtakes = 0;
    int          pend_owner = 0;   // 0 none, 1 instr, 2 data
    bit          pend_bad = 1'b0;

    always @(negedge clk) begin
        int          win;
        bit          bad;
        logic [31:0] off, exp_mask;
        logic        sel_we;
        logic [31:0] sel_addr, sel_wdata;
        logic [3:0]  sel_strb;

        win = 0;
        if (!rst_i) begin
            if (instr_req_i && (overtakes >= MAX_BURST || !data_req_i)) win = 1;
            else if (data_req_i) win = 2;
        end
        check("m_instr_gnt", 32'(instr_gnt_o), 32'(win == 1));
        check("m_data_gnt", 32'(data_gnt_o), 32'(win == 2));

        sel_addr  = (win == 1) ? instr_addr_i  : data_addr_i;
        sel_we    = (win == 1) ? instr_we_i    : data_we_i;
        sel_wdata = (win == 1) ? instr_wdata_i : data_wdata_i;
        sel_strb  = (win == 1) ? instr_strb_i  : data_strb_i;
        off = sel_addr - BASE;
        bad = longint'(off) >= longint'(MEM_DEPTH) * 4;

        if (win == 0) begin
            check("m_idle_bus", {mem_req_o, mem_we_o, 30'(mem_addr_o)}, 32'h0);
            check("m_idle_wdata", mem_wdata_o, 32'h0);
            check("m_idle_wmask", mem_wmask_o, 32'h0);
        end else if (bad) begin
            check("m_oor_req", 32'(mem_req_o), 32'h0);
        end else begin
            exp_mask = 32'h0;
            for (int b = 0; b < 4; b++)
                if (sel_strb[b]) exp_mask = exp_mask | (32'hFF << (8 * b));
            check("m_mem_req", 32'(mem_req_o), 32'h1);
            check("m_mem_we", 32'(mem_we_o), 32'(sel_we));
            check("m_mem_addr", 32'(mem_addr_o), off / 4);
            check("m_mem_wdata", mem_wdata_o, sel_wdata);
            check("m_mem_wmask", mem_wmask_o, exp_mask);
        end

        check("m_instr_rvalid", 32'(instr_rvalid_o), 32'(!rst_i && pend_owner == 1));
        check("m_data_rvalid", 32'(data_rvalid_o), 32'(!rst_i && pend_owner == 2));
        check("m_instr_err", 32'(instr_err_o), 32'(!rst_i && pend_owner == 1 && pend_bad));
        check("m_data_err", 32'(data_err_o), 32'(!rst_i && pend_owner == 2 && pend_bad));
        check("m_instr_rdata", instr_rdata_o,
              (!rst_i && pend_owner == 1 && !pend_bad) ? mem_rdata_i : 32'h0);
        check("m_data_rdata", data_rdata_o,
              (!rst_i && pend_owner == 2 && !pend_bad) ? mem_rdata_i : 32'h0);

        if (rst_i) begin
            pend_owner = 0;
            pend_bad   = 1'b0;
            overtakes  = 0;
        end else begin
            pend_owner = win;
            pend_bad   = (win != 0) && bad;
            if (!instr_req_i || win == 1) overtakes = 0;
            else if (win == 2 && overtakes < MAX_BURST) overtakes++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
        mem_rdata_i = $urandom;
    endtask

    task automatic set_instr(input logic req, input logic [31:0] addr, input logic we,
                             input logic [31:0] wdata, input logic [3:0] strb);
        instr_req_i = req; instr_addr_i = addr; instr_we_i = we;
        instr_wdata_i = wdata; instr_strb_i = strb;
    endtask

    task automatic set_data(input logic req, input logic [31:0] addr, input logic we,
                            input logic [31:0] wdata, input logic [3:0] strb);
        data_req_i = req; data_addr_i = addr; data_we_i = we;
        data_wdata_i = wdata; data_strb_i = strb;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return $urandom;
            1:       return BASE - 32'd4;
            2:       return BASE + SPAN - 32'd4;
            3:       return BASE + SPAN;
            default: return BASE + $urandom_range(0, SPAN - 1);
        endcase
    endfunction

    initial begin
        string got;
        int    n_gnt, n_rv;
        logic  ig, dg;

        rst_i = 1'b1;
        mem_rdata_i = 32'h0;
        set_instr(1'b1, BASE, 1'b0, 32'h0, 4'hF);
        set_data(1'b1, BASE + 32'd4, 1'b0, 32'h0, 4'hF);

        // Reset holds everything quiet even with both ports requesting.
        repeat (3) begin
            cycle();
            #2;
            check("rst_gnt", {30'h0, instr_gnt_o, data_gnt_o}, 32'h0);
            check("rst_mem_req", 32'(mem_req_o), 32'h0);
            check("rst_rvalid", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);
        end
        cycle();
        rst_i = 1'b0;
        set_instr(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        set_data(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);

        // Single data read.
        cycle();
        set_data(1'b1, 32'h8000_0010, 1'b0, 32'h0, 4'hF);
        #2;
        check("rd_gnt", 32'(data_gnt_o), 32'h1);
        check("rd_mem_req", 32'(mem_req_o), 32'h1);
        check("rd_mem_addr", 32'(mem_addr_o), 32'h4);
        cycle();
        set_data(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        #2;
        check("rd_rvalid", 32'(data_rvalid_o), 32'h1);
        check("rd_rdata", data_rdata_o, mem_rdata_i);
        check("rd_instr_rvalid", 32'(instr_rvalid_o), 32'h0);

        // Data write with partial strobes.
        cycle();
        set_data(1'b1, 32'h8000_0100, 1'b1, 32'hAABB_CCDD, 4'b0101);
        #2;
        check("wr_mem_we", 32'(mem_we_o), 32'h1);
        check("wr_wmask", mem_wmask_o, 32'h00FF_00FF);
        check("wr_wdata", mem_wdata_o, 32'hAABB_CCDD);
        cycle();
        set_data(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        #2;
        check("wr_rvalid", 32'(data_rvalid_o), 32'h1);
        check("wr_err", 32'(data_err_o), 32'h0);

        // Out-of-range fetches just below the base and just past the end.
        cycle();
        set_instr(1'b1, 32'h7FFF_FFFC, 1'b0, 32'h0, 4'hF);
        #2;
        check("oor_lo_gnt", 32'(instr_gnt_o), 32'h1);
        check("oor_lo_mem_req", 32'(mem_req_o), 32'h0);
        cycle();
        set_instr(1'b1, 32'h8040_0000, 1'b0, 32'h0, 4'hF);
        #2;
        check("oor_hi_gnt", 32'(instr_gnt_o), 32'h1);
        check("oor_hi_mem_req", 32'(mem_req_o), 32'h0);
        check("oor_lo_rsp", {29'h0, instr_rvalid_o, instr_err_o, data_rvalid_o}, 32'h6);
        check("oor_lo_rdata", instr_rdata_o, 32'h0);
        cycle();
        set_instr(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        #2;
        check("oor_hi_rsp", {29'h0, instr_rvalid_o, instr_err_o, data_rvalid_o}, 32'h6);
        check("oor_hi_rdata", instr_rdata_o, 32'h0);

        // Both ports request continuously: fetch is forced after four data grants.
        got = "";
        n_rv = 0;
        for (int i = 0; i < 11; i++) begin
            cycle();
            set_instr(i < 10, BASE + 32'(i * 8), 1'b0, 32'h0, 4'hF);
            set_data(i < 10, BASE + 32'h100 + 32'(i * 4), 1'b0, 32'h0, 4'hF);
            #2;
            if (i < 10) got = {got, data_gnt_o ? "D" : (instr_gnt_o ? "I" : "-")};
            if (i > 0) n_rv += int'(instr_rvalid_o) + int'(data_rvalid_o);
        end
        tests++;
        if (got != "DDDDIDDDDI") begin
            fails++;
            $display("FAIL burst_seq: got %s, expected DDDDIDDDDI", got);
        end
        check("burst_rvalids", 32'(n_rv), 32'd10);

        // Reset right after a grant drops its response.
        cycle();
        set_instr(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        set_data(1'b1, BASE + 32'd8, 1'b0, 32'h0, 4'hF);
        #2;
        check("mid_gnt", 32'(data_gnt_o), 32'h1);
        cycle();
        rst_i = 1'b1;
        set_instr(1'b1, BASE, 1'b0, 32'h0, 4'hF);
        #2;
        check("mid_rst_rvalid", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);
        check("mid_rst_gnt", {30'h0, instr_gnt_o, data_gnt_o}, 32'h0);
        check("mid_rst_mem", {mem_req_o, mem_we_o, 30'(mem_addr_o)}, 32'h0);
        cycle();
        rst_i = 1'b0;
        #2;
        check("post_rst_gnt", {30'h0, instr_gnt_o, data_gnt_o}, 32'h1);
        cycle();
        set_instr(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        set_data(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        #2;
        check("post_rst_rvalid", 32'(data_rvalid_o), 32'h1);

        // Instruction-only stream of eight fetches.
        n_gnt = 0;
        n_rv  = 0;
        for (int i = 0; i < 9; i++) begin
            cycle();
            set_instr(i < 8, BASE + 32'(i * 4), 1'b0, 32'h0, 4'hF);
            #2;
            n_gnt += int'(instr_gnt_o);
            n_rv  += int'(instr_rvalid_o);
        end
        cycle();
        #2;
        n_rv += int'(instr_rvalid_o);
        check("ionly_gnts", 32'(n_gnt), 32'd8);
        check("ionly_rvalids", 32'(n_rv), 32'd8);

        // Randomized traffic; each requester holds its request until granted.
        ig = 1'b0;
        dg = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            rst_i = ($urandom_range(0, 149) == 0);
            if (!instr_req_i || ig)
                set_instr($urandom_range(0, 9) < 6, rand_addr(), 1'($urandom), $urandom, 4'($urandom));
            if (!data_req_i || dg)
                set_data($urandom_range(0, 9) < 6, rand_addr(), 1'($urandom), $urandom, 4'($urandom));
            #2;
            ig = instr_gnt_o;
            dg = data_gnt_o;
        end

        cycle();
        rst_i = 1'b0;
        set_instr(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        set_data(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        repeat (2) cycle();
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
